// File: rtl/membus_arbiter_if.sv
// Request/response bundle between two requesters (I, D), the arbiter and a single memory port.
// slave: the arbiter's view; master: the requesters' and memory's view.
interface membus_arbiter_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 64
);
  localparam int MASK_WIDTH = DATA_WIDTH / 8;

  logic                  i_valid;
  logic                  i_ready;
  logic                  i_wen;
  logic [ADDR_WIDTH-1:0] i_addr;
  logic [DATA_WIDTH-1:0] i_wdata;
  logic [MASK_WIDTH-1:0] i_wmask;
  logic                  i_rvalid;
  logic [DATA_WIDTH-1:0] i_rdata;

  logic                  d_valid;
  logic                  d_ready;
  logic                  d_wen;
  logic [ADDR_WIDTH-1:0] d_addr;
  logic [DATA_WIDTH-1:0] d_wdata;
  logic [MASK_WIDTH-1:0] d_wmask;
  logic                  d_rvalid;
  logic [DATA_WIDTH-1:0] d_rdata;

  logic                  mem_valid;
  logic                  mem_wen;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [MASK_WIDTH-1:0] mem_wmask;
  logic                  mem_rvalid;
  logic [DATA_WIDTH-1:0] mem_rdata;

  logic                  resp_err;

  modport slave (
    input  i_valid, i_wen, i_addr, i_wdata, i_wmask,
    output i_ready, i_rvalid, i_rdata,
    input  d_valid, d_wen, d_addr, d_wdata, d_wmask,
    output d_ready, d_rvalid, d_rdata,
    output mem_valid, mem_wen, mem_addr, mem_wdata, mem_wmask,
    input  mem_rvalid, mem_rdata,
    output resp_err
  );

  modport master (
    output i_valid, i_wen, i_addr, i_wdata, i_wmask,
    input  i_ready, i_rvalid, i_rdata,
    output d_valid, d_wen, d_addr, d_wdata, d_wmask,
    input  d_ready, d_rvalid, d_rdata,
    input  mem_valid, mem_wen, mem_addr, mem_wdata, mem_wmask,
    output mem_rvalid, mem_rdata,
    input  resp_err
  );
endinterface

// File: rtl/membus_arbiter.sv
// Two-requester memory arbiter with zero-latency request pass-through and an in-order owner queue
// for response routing. Define ARB_DATA_PRIORITY_EN to give D fixed priority instead of round-robin.
//
// Handshake: a request transfers in any cycle where x_valid && x_ready; the requester holds its
// fields stable until then. Memory accepts every mem_valid and returns one mem_rvalid per request,
// in order; responses reach their owner through x_rvalid in the same cycle (no ready on responses).
module membus_arbiter #(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 64,
  parameter int OUTSTANDING = 2
) (
  input logic                clk,
  input logic                rst,
  membus_arbiter_if.slave    bus
);
  localparam int MASK_WIDTH = DATA_WIDTH / 8;
  localparam int PTR_W      = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam int CNT_W      = $clog2(OUTSTANDING + 1);
  localparam logic OWNER_I  = 1'b0;
  localparam logic OWNER_D  = 1'b1;

  logic             owner_q [OUTSTANDING];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] occupancy;
  logic             full;
  logic             empty;
  logic             grant_i;
  logic             grant_d;
  logic             i_ready;
  logic             d_ready;
  logic             accept;
  logic             pop;
  logic             head_owner;
  logic             i_rvalid;
  logic             d_rvalid;
  logic             err_q;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  // Full uses registered occupancy only, so a same-cycle pop never frees a slot early.
  assign full  = (occupancy == CNT_W'(OUTSTANDING));
  assign empty = (occupancy == '0);

`ifdef ARB_DATA_PRIORITY_EN
  always_comb begin
    grant_d = bus.d_valid;
    grant_i = bus.i_valid && !bus.d_valid;
  end
`else
  logic last_d;

  always_comb begin
    grant_i = bus.i_valid && (!bus.d_valid || last_d);
    grant_d = bus.d_valid && !grant_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_d <= 1'b1;
    end else if (accept) begin
      last_d <= grant_d;
    end
  end
`endif

  assign i_ready = grant_i && !full && !rst;
  assign d_ready = grant_d && !full && !rst;
  assign accept  = i_ready || d_ready;

  assign bus.i_ready   = i_ready;
  assign bus.d_ready   = d_ready;
  assign bus.mem_valid = accept;

  always_comb begin
    bus.mem_wen   = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_wmask = '0;
    if (i_ready) begin
      bus.mem_wen   = bus.i_wen;
      bus.mem_addr  = bus.i_addr;
      bus.mem_wdata = bus.i_wdata;
      bus.mem_wmask = bus.i_wmask;
    end else if (d_ready) begin
      bus.mem_wen   = bus.d_wen;
      bus.mem_addr  = bus.d_addr;
      bus.mem_wdata = bus.d_wdata;
      bus.mem_wmask = bus.d_wmask;
    end
  end

  // Responses are routed by the head of the owner queue; an orphan response is dropped.
  assign head_owner = owner_q[rd_ptr];
  assign pop        = bus.mem_rvalid && !empty && !rst;
  assign i_rvalid   = pop && (head_owner == OWNER_I);
  assign d_rvalid   = pop && (head_owner == OWNER_D);

  assign bus.i_rvalid = i_rvalid;
  assign bus.d_rvalid = d_rvalid;
  assign bus.i_rdata  = i_rvalid ? bus.mem_rdata : '0;
  assign bus.d_rdata  = d_rvalid ? bus.mem_rdata : '0;
  assign bus.resp_err = err_q;

  always_ff @(posedge clk) begin
    if (accept) begin
      owner_q[wr_ptr] <= d_ready ? OWNER_D : OWNER_I;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
      err_q     <= 1'b0;
    end else begin
      if (accept) begin
        wr_ptr <= next_ptr(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      case ({accept, pop})
        2'b10:   occupancy <= occupancy + 1'b1;
        2'b01:   occupancy <= occupancy - 1'b1;
        default: occupancy <= occupancy;
      endcase
      if (bus.mem_rvalid && empty) begin
        err_q <= 1'b1;
      end
    end
  end

  // Keeps MASK_WIDTH referenced for readers matching this module against the interface widths.
  localparam int MASK_CHECK = MASK_WIDTH;
endmodule
